// File: rtl/adpcm_pkg.sv
// adpcm_pkg: shared types and helpers for the ADPCM frame transmitter.
// Holds the TX state enum, FIFO entry width helper and config checks.
package adpcm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_e;

    localparam int MIN_GAP   = 1;
    localparam int MIN_DEPTH = 2;

    // FIFO entry is {last, data}
    function automatic int entry_w(input int data_w);
        return data_w + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v >= MIN_DEPTH) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit cfg_ok(input int depth, input int gap);
        return is_pow2(depth) && (gap >= MIN_GAP);
    endfunction

endpackage

// File: rtl/adpcm_sync_fifo.sv
// adpcm_sync_fifo: single-clock FIFO with show-ahead read data.
// Ports: push/wdata in, pop/rdata out, full, empty, count (0..DEPTH).
module adpcm_sync_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/adpcm_frame_tx.sv
// adpcm_frame_tx: buffers samples and sends only complete frames on the link.
// Ports: s_valid/s_ready/s_data/s_last in; frame/data link, busy, frame_cnt, trunc_err out.
module adpcm_frame_tx
    import adpcm_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 16,
    parameter int GAP    = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              frame,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              trunc_err
);

    localparam int EW = entry_w(DATA_W);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    if (!cfg_ok(DEPTH, GAP)) begin : g_bad_cfg
        $error("adpcm_frame_tx: DEPTH must be a power of 2 >= 2, GAP >= 1");
    end

    tx_state_e         state_q, state_d;
    logic [CW-1:0]     pend_q, pend_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              frame_q, frame_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              trunc_q, trunc_d;

    logic              push, pop, trunc, take;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [EW-1:0]     fifo_rdata;
    logic              wr_last;
    logic              head_last;
    logic [DATA_W-1:0] head_data;

    assign head_last = fifo_rdata[DATA_W];
    assign head_data = fifo_rdata[DATA_W-1:0];

    adpcm_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({wr_last, s_data}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        push = s_valid && !fifo_full;

        state_d = state_q;
        gap_d   = gap_q;
        pop     = 1'b0;
        frame_d = 1'b0;
        data_d  = '0;
        last_d  = 1'b0;

        // IDLE pops only once a whole frame is buffered; SEND keeps popping.
        take = !fifo_empty &&
               ((state_q == ST_SEND) ||
                ((state_q == ST_IDLE) && (pend_q != '0)));

        unique case (state_q)
            ST_IDLE, ST_SEND: begin
                if (take) begin
                    pop     = 1'b1;
                    frame_d = 1'b1;
                    data_d  = head_data;
                    last_d  = head_last;
                    if (head_last) begin
                        state_d = ST_GAP;
                        gap_d   = GW'(GAP - 1);
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Nothing is popped while no frame is pending, so a push that
        // fills the FIFO with no terminator must close the frame itself.
        trunc = push && !s_last && (pend_q == '0) &&
                (fifo_count == CW'(DEPTH - 1)) && !pop;
        wr_last = s_last || trunc;
        trunc_d = trunc;

        pend_d = pend_q;
        unique case ({push && wr_last, pop && head_last})
            2'b10:   pend_d = pend_q + CW'(1);
            2'b01:   pend_d = pend_q - CW'(1);
            default: pend_d = pend_q;
        endcase

        // Counted as the final beat leaves the link.
        cnt_d = cnt_q + CNT_W'(frame_q && last_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            gap_q   <= '0;
            frame_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            gap_q   <= gap_d;
            frame_q <= frame_d;
            data_q  <= data_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
        end
    end

    assign s_ready   = !fifo_full;
    assign frame     = frame_q;
    assign data      = data_q;
    assign busy      = (state_q != ST_IDLE) || (pend_q != '0);
    assign frame_cnt = cnt_q;
    assign trunc_err = trunc_q;

endmodule

// File: tb/tb_adpcm_frame_tx.sv
// tb_adpcm_frame_tx: directed scoreboard bench for adpcm_frame_tx.
// Expected beats are queued at each accepted push and checked on the link.
module tb_adpcm_frame_tx;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 16;
    localparam int GAP    = 3;
    localparam int CNT_W  = 2;

    logic              clk;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              frame;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic [CNT_W-1:0]  frame_cnt;
    logic              trunc_err;

    adpcm_frame_tx #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .GAP    (GAP),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .frame     (frame),
        .data      (data),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .trunc_err (trunc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              e;
    } exp_t;

    exp_t             exp_q[$];
    int               tests;
    int               fails;
    int               cyc;
    int               hs_cyc;
    int               rise_cyc;
    int               beats;
    int               gap_run;
    int               trunc_seen;
    bit               have_prev;
    logic             frame_prev;
    logic             end_pend;
    logic [CNT_W-1:0] cnt_model;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        frame_prev = 1'b0;
        end_pend   = 1'b0;
        have_prev  = 1'b0;
        gap_run    = 0;
        beats      = 0;
        trunc_seen = 0;
        cnt_model  = '0;
    endtask

    task automatic monitor();
        exp_t e;
        if (end_pend) begin
            chk("frame_fall", frame, 1'b0);
            cnt_model++;
        end else if (frame_prev) begin
            chk("frame_cont", frame, 1'b1);
        end
        end_pend = 1'b0;
        chk("frame_cnt", frame_cnt, cnt_model);
        if (trunc_err) trunc_seen++;
        if (frame) begin
            if (!frame_prev) begin
                rise_cyc = cyc;
                if (have_prev) chk("gap", gap_run >= GAP, 1'b1);
            end
            beats++;
            chk("beat_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("data", data, e.d);
                end_pend = e.e;
            end
            gap_run   = 0;
            have_prev = 1'b1;
        end else begin
            chk("idle_data", data, '0);
            gap_run++;
        end
        frame_prev = frame;
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (!rst) monitor();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        cycle();
        chk("rst_frame", frame, 1'b0);
        chk("rst_data", data, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cnt", frame_cnt, '0);
        chk("rst_trunc", trunc_err, 1'b0);
        chk("rst_ready", s_ready, 1'b1);
        rst = 1'b0;
        clear_model();
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d, input logic l,
                             input logic e, output int stalls);
        bit acc;
        exp_t x;
        acc    = 1'b0;
        stalls = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!acc && stalls < 50) begin
            if (s_ready) begin
                acc = 1'b1;
                x.d = d;
                x.e = e;
                exp_q.push_back(x);
                if (l) hs_cyc = cyc;
            end else begin
                stalls++;
            end
            cycle();
        end
        chk("push_accept", acc, 1'b1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || frame || end_pend) && n < 400) begin
            cycle();
            n++;
        end
        chk("drain", n < 400, 1'b1);
        exp_q.delete();
    endtask

    initial begin
        int st;
        int g;
        logic [CNT_W-1:0] wrap_seq [5];
        tests   = 0;
        fails   = 0;
        cyc     = 0;
        hs_cyc  = 0;
        rise_cyc = 0;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        clear_model();
        repeat (2) cycle();

        // single frame latency and content
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            send_word(DATA_W'(i), i == 4, i == 4, st);
        end
        wait_idle();
        chk("t1_latency", rise_cyc - hs_cyc, 2);
        chk("t1_beats", beats, 4);
        chk("t1_cnt", frame_cnt, 2'd1);

        // back-to-back frames separated by GAP
        do_reset();
        send_word(4'hA, 1'b0, 1'b0, st);
        send_word(4'hB, 1'b1, 1'b1, st);
        send_word(4'hC, 1'b0, 1'b0, st);
        send_word(4'hD, 1'b0, 1'b0, st);
        send_word(4'hE, 1'b1, 1'b1, st);
        wait_idle();
        chk("t2_beats", beats, 5);
        chk("t2_cnt", frame_cnt, 2'd2);

        // truncation: 20 words, terminator only on the last
        do_reset();
        for (int i = 0; i < 20; i++) begin
            send_word(DATA_W'(i), i == 19, (i == 15) || (i == 19), st);
        end
        wait_idle();
        chk("t3_trunc", trunc_seen, 1);
        chk("t3_beats", beats, 20);
        chk("t3_cnt", frame_cnt, 2'd2);

        // backpressure: full FIFO refuses one word, then takes it
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            send_word(DATA_W'(15 - i), i == DEPTH - 1, i == DEPTH - 1, st);
        end
        chk("t4_full_ready", s_ready, 1'b0);
        send_word(4'h9, 1'b1, 1'b1, st);
        chk("t4_stall", st, 1);
        wait_idle();
        chk("t4_beats", beats, DEPTH + 1);
        chk("t4_cnt", frame_cnt, 2'd2);
        chk("t4_trunc", trunc_seen, 0);

        // reset during beat 2 of a 5-beat frame
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_word(DATA_W'(i + 3), i == 4, i == 4, st);
        end
        g = 0;
        while (beats < 2 && g < 50) begin
            cycle();
            g++;
        end
        chk("t5_reach_beat2", beats, 2);
        do_reset();
        send_word(4'h7, 1'b0, 1'b0, st);
        send_word(4'h8, 1'b0, 1'b0, st);
        send_word(4'h6, 1'b1, 1'b1, st);
        wait_idle();
        chk("t5_beats", beats, 3);
        chk("t5_cnt", frame_cnt, 2'd1);

        // frame counter wraps at 2^CNT_W
        wrap_seq[0] = 2'd1;
        wrap_seq[1] = 2'd2;
        wrap_seq[2] = 2'd3;
        wrap_seq[3] = 2'd0;
        wrap_seq[4] = 2'd1;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send_word(DATA_W'(k + 1), 1'b1, 1'b1, st);
            wait_idle();
            chk("t6_wrap", frame_cnt, wrap_seq[k]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adpcm_frame_tx.md
Name: adpcm_frame_tx

Overview:
Parametrised ADPCM frame transmitter. It buffers sample words from an upstream valid/ready stream and serialises only complete frames onto the frame/data link bus. It generalises the fixed 4-bit frame/data link to any data width and buffer depth, with a programmable inter-frame gap and oversize-frame truncation. It sits between the sample source and the link pins that the monitor clocking block samples.

Parameters:
DATA_W, 4, width of the data link and of each sample word
DEPTH, 16, FIFO entries; also the maximum frame length in beats; power of 2, minimum 2
GAP, 1, idle cycles forced between frames; minimum 1
CNT_W, 16, width of the sent-frame counter

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  synchronous reset, active-high
s_valid  in  1  input sample valid
s_ready  out  1  input can accept; equals !fifo_full
s_data  in  DATA_W  sample word
s_last  in  1  marks the final word of a frame
frame  out  1  link frame strobe; high for every beat of a frame
data  out  DATA_W  link data; valid while frame=1, else 0
busy  out  1  high in SEND or GAP, or when frames_pending!=0
frame_cnt  out  CNT_W  number of frames fully transmitted; wraps
trunc_err  out  1  one-cycle pulse when a frame is force-terminated

Behaviour:
- Reset: the following all become 0 on the cycle after rst is sampled high:
  - frame, data, busy, trunc_err, frame_cnt
  - FIFO count, frames_pending, gap counter
  - state, which goes to IDLE.
- Reset mid-frame: frame drops on the next edge and buffered data is discarded.
- Push: occurs on s_valid && s_ready. Each FIFO entry is {last, data}.
- Pop: occurs only under the FSM conditions below.
- frames_pending (0..DEPTH):
  - +1 when an entry with last=1 is pushed.
  - -1 when an entry with last=1 is popped.
  - Unchanged when both happen in the same cycle.
- Truncation:
  - Trigger: a push would fill the FIFO (count becomes DEPTH), s_last=0, and frames_pending=0.
  - The entry is stored with last=1 and trunc_err pulses on the next cycle.
  - The next accepted word starts a new frame.
- FSM states: IDLE, SEND, GAP.
  - IDLE: if frames_pending!=0, pop the head and go to SEND.
  - SEND: registered outputs give frame=1 and data=popped word. Pop one entry every cycle.
  - Underrun in SEND cannot happen, because a complete frame is always buffered before SEND starts.
  - SEND, when the popped entry has last=1: the next state is GAP and the gap counter loads GAP-1.
  - GAP: frame=0, data=0, counter decrements. At 0 go to IDLE.
  - frame_cnt increments by 1, mod 2^CNT_W, on the cycle frame deasserts after a final beat.
- Latency:
  - When idle with an empty FIFO, frame first rises 2 cycles after the s_last handshake.
  - Each frame is N consecutive frame=1 cycles, in input order.
  - At least GAP cycles with frame=0 separate frames.
  - The minimum next-frame start after the last beat is GAP+1 cycles, including the IDLE pop cycle.
- Simultaneous push and pop while full: not allowed. s_ready is based on registered fullness.
- The data output is forced to 0 whenever frame=0.

Decomposition:
- Package adpcm_pkg holds:
  - typedef enum tx_state_e {IDLE, SEND, GAP}
  - parametrised entry struct {last, data}, or a helper function for the entry width DATA_W+1
  - localparam checks: DEPTH a power of 2, GAP>=1.
- Sub-module adpcm_sync_fifo (WIDTH, DEPTH) provides:
  - ports: push, pop, wdata, rdata, full, empty, count
  - registered pointers plus a count of $clog2(DEPTH)+1 bits
  - synchronous reset.
- The top level holds the FSM, frames_pending, the gap counter and frame_cnt.

Test Plan:
- Single frame, DATA_W=4: push 0x1,0x2,0x3,0x4(last) back-to-back from idle -> frame high for exactly 4 cycles, starting 2 cycles after the last handshake; data=1,2,3,4; frame_cnt=1; data=0 afterwards.
- Back-to-back frames, GAP=3: push frame A (2 words), then B (3 words) immediately -> A beats, then at least 3 frame=0 cycles, then B's 3 beats; frame_cnt=2.
- Truncation, DEPTH=16: push 20 words with s_last only on the 20th -> trunc_err pulses once; first frame is 16 beats; second frame is 4 beats; frame_cnt=2.
- Backpressure: stall transmission until the FIFO holds DEPTH entries -> s_ready=0; an extra s_valid word is not accepted and is not lost when later presented; s_ready returns to 1 after the first pop.
- Reset mid-frame: assert rst during beat 2 of a 5-beat frame -> next cycle frame=0, busy=0, frame_cnt=0; a subsequent new frame transmits correctly.
- Counter wrap, CNT_W=2: send 5 one-word frames -> frame_cnt sequence 1,2,3,0,1.
